adat_frame_builder: RTL and testbench

Builds the 256-bit ADAT optical frame from eight 24-bit channel samples and 4 user bits, and emits it one bit per clock as raw (pre-NRZI) data. Sits directly upstream of the NRZI encoder in the ADAT output path, whose `in` is driven from `out`. `clk` is the ADAT bit clock (256 × Fs, e.g. 12.288 MHz at 48 kHz), so every clock cycle carries exactly one frame bit. Samples are loaded through a write/commit port into a shadow bank, buffered once more, then transferred to the active frame only at a frame boundary.

---
 rtl/adat_frame_builder_if.sv | 23 ++
 rtl/adat_frame_builder.sv | 104 ++++++++++
 tb/tb_adat_frame_builder.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/adat_frame_builder_if.sv
// Producer-side bus of the ADAT frame builder: sample write/commit port plus
// the serial frame outputs that feed the NRZI encoder.
interface adat_frame_builder_if;
    logic        wr_en;
    logic [2:0]  wr_ch;
    logic [23:0] wr_data;
    logic [3:0]  user_in;
    logic        commit;
    logic        out;
    logic        frame_start;
    logic        underrun;
    logic        overrun;

    modport master (
        output wr_en, wr_ch, wr_data, user_in, commit,
        input  out, frame_start, underrun, overrun
    );

    modport slave (
        input  wr_en, wr_ch, wr_data, user_in, commit,
        output out, frame_start, underrun, overrun
    );
endinterface

// File: rtl/adat_frame_builder.sv
// Triple-buffered (shadow -> pending -> active) ADAT frame builder; emits one
// raw pre-NRZI frame bit per bit-clock cycle.
module adat_frame_builder (
    input  logic                  clk,
    input  logic                  rst_n,
    adat_frame_builder_if.slave   bus
);
    typedef struct packed {
        logic [7:0][23:0] ch;
        logic [3:0]       user;
    } bank_t;

    logic [7:0][23:0] shadow_q, shadow_d;
    bank_t            pend_q, pend_d;
    bank_t            act_q, act_d;
    logic             pend_valid_q, pend_valid_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             frame_start_q, frame_start_d;
    logic             underrun_q, underrun_d;
    logic             overrun_q, overrun_d;
    logic             boundary;
    logic [255:0]     frame;

    // Static frame image of the active bank; frame[i] is wire bit i.
    assign frame[9:0] = '0;
    assign frame[10]  = 1'b1;

    for (genvar k = 0; k < 49; k++) begin : g_grp
        logic [3:0] nib;
        if (k == 0) begin : g_user
            assign nib = act_q.user;
        end else begin : g_chan
            assign nib = act_q.ch[(k-1)/6][23-4*((k-1)%6) -: 4];
        end
        for (genvar m = 0; m < 4; m++) begin : g_bit
            assign frame[11+5*k+m] = nib[3-m];
        end
        assign frame[15+5*k] = 1'b1;
    end

    assign boundary = (cnt_q == 8'd0);

    always_comb begin
        shadow_d      = shadow_q;
        pend_d        = pend_q;
        pend_valid_d  = pend_valid_q;
        act_d         = act_q;
        underrun_d    = 1'b0;
        overrun_d     = 1'b0;
        out_d         = frame[cnt_q];
        frame_start_d = boundary;
        cnt_d         = cnt_q + 8'd1;

        if (bus.wr_en) shadow_d[bus.wr_ch] = bus.wr_data;

        // Load happens before a same-edge commit, so the boundary takes the old pending bank.
        if (boundary) begin
            if (pend_valid_q) begin
                act_d        = pend_q;
                pend_valid_d = 1'b0;
            end else begin
                underrun_d   = 1'b1;
            end
        end

        // Commit copies the pre-write shadow; a same-edge write lands afterwards.
        if (bus.commit) begin
            pend_d.ch    = shadow_q;
            pend_d.user  = bus.user_in;
            pend_valid_d = 1'b1;
            if (pend_valid_q && !boundary) overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q      <= '0;
            pend_q        <= '0;
            act_q         <= '0;
            pend_valid_q  <= 1'b0;
            cnt_q         <= '0;
            out_q         <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            shadow_q      <= shadow_d;
            pend_q        <= pend_d;
            act_q         <= act_d;
            pend_valid_q  <= pend_valid_d;
            cnt_q         <= cnt_d;
            out_q         <= out_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
            overrun_q     <= overrun_d;
        end
    end

    assign bus.out         = out_q;
    assign bus.frame_start = frame_start_q;
    assign bus.underrun    = underrun_q;
    assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_adat_frame_builder.sv
// Scoreboard bench for adat_frame_builder: the driver queues the expected
// {out, frame_start, underrun, overrun} per cycle, a monitor pops and compares.
module tb_adat_frame_builder;
    typedef struct packed {
        logic [7:0][23:0] ch;
        logic [3:0]       user;
    } bank_t;

    typedef struct {
        logic [3:0] v;
        int         fr;
        int         bt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    adat_frame_builder_if bus ();

    adat_frame_builder dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    exp_t q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    bit   mon_en  = 1'b0;
    int   bcnt    = 0;
    int   fnum    = 0;

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b want %b (out,frame_start,underrun,overrun)", nm, act, exp);
    endtask

    // Wire bit i of a frame carrying bank b, written from the layout description.
    function automatic logic exp_bit(input bank_t b, input int i);
        int j, k, m, c, n;
        logic [3:0] nib;
        if (i < 10) return 1'b0;
        if (i == 10) return 1'b1;
        j = i - 11;
        k = j / 5;
        m = j % 5;
        if (m == 4) return 1'b1;
        if (k == 0) nib = b.user;
        else begin
            c = (k - 1) / 6;
            n = (k - 1) % 6;
            nib = 4'(b.ch[c] >> (20 - 4 * n));
        end
        return nib[3-m];
    endfunction

    task automatic step(input bank_t fr, input bit urf, input bit we, input logic [2:0] ch,
                        input logic [23:0] d, input bit cm, input logic [3:0] u, input bit eov);
        exp_t e;
        bus.wr_en   = we;
        bus.wr_ch   = ch;
        bus.wr_data = d;
        bus.commit  = cm;
        bus.user_in = u;
        e.v  = {exp_bit(fr, bcnt), bcnt == 0, urf && (bcnt == 0), eov};
        e.fr = fnum;
        e.bt = bcnt;
        q.push_back(e);
        @(negedge clk);
        bcnt = (bcnt + 1) % 256;
        if (bcnt == 0) fnum++;
    endtask

    task automatic idle(input bank_t fr, input bit urf);
        step(fr, urf, 1'b0, 3'd0, 24'd0, 1'b0, 4'd0, 1'b0);
    endtask

    always @(posedge clk) begin
        if (mon_en) begin
            #1;
            if (q.size() == 0) begin
                n_total++;
                $display("FAIL monitor_queue: output seen with no expected entry");
            end else begin
                exp_t e;
                e = q.pop_front();
                chk($sformatf("frame%0d_bit%0d", e.fr, e.bt),
                    {bus.out, bus.frame_start, bus.underrun, bus.overrun}, e.v);
            end
        end
    end

    initial begin
        bank_t z, b1, b2, b3, b4;
        z = '0;
        b1 = z;  b1.ch[0] = 24'hABCDEF; b1.ch[7] = 24'h000001; b1.user = 4'hA;
        b2 = b1; b2.ch[3] = 24'h222222; b2.user = 4'h5;
        b3 = b2; b3.ch[1] = 24'h123456; b3.user = 4'h3;
        b4 = b3; b4.ch[1] = 24'h654321; b4.user = 4'hC;

        bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_data = '0; bus.commit = 1'b0; bus.user_in = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {bus.out, bus.frame_start, bus.underrun, bus.overrun}, 4'b0000);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Frames 0,1: empty payload, underrun every frame.
        repeat (512) idle(z, 1'b1);

        // Frame 2: load ch0/ch7 and commit at cnt 40; this frame stays empty.
        for (int b = 0; b < 256; b++) begin
            case (b)
                5:       step(z, 1'b1, 1'b1, 3'd0, 24'hABCDEF, 1'b0, 4'h0, 1'b0);
                6:       step(z, 1'b1, 1'b1, 3'd7, 24'h000001, 1'b0, 4'h0, 1'b0);
                40:      step(z, 1'b1, 1'b0, 3'd0, 24'h0,      1'b1, 4'hA, 1'b0);
                default: idle(z, 1'b1);
            endcase
        end

        // Frame 3: carries b1; two commits with different ch3, second overruns.
        for (int b = 0; b < 256; b++) begin
            case (b)
                10:      step(b1, 1'b0, 1'b1, 3'd3, 24'h111111, 1'b0, 4'h0, 1'b0);
                20:      step(b1, 1'b0, 1'b0, 3'd0, 24'h0,      1'b1, 4'h5, 1'b0);
                30:      step(b1, 1'b0, 1'b1, 3'd3, 24'h222222, 1'b0, 4'h0, 1'b0);
                50:      step(b1, 1'b0, 1'b0, 3'd0, 24'h0,      1'b1, 4'h5, 1'b1);
                default: idle(b1, 1'b0);
            endcase
        end

        // Frame 4: carries b2; commit b3, then pre-load ch1 for the boundary commit.
        for (int b = 0; b < 256; b++) begin
            case (b)
                10:      step(b2, 1'b0, 1'b1, 3'd1, 24'h123456, 1'b0, 4'h0, 1'b0);
                100:     step(b2, 1'b0, 1'b0, 3'd0, 24'h0,      1'b1, 4'h3, 1'b0);
                200:     step(b2, 1'b0, 1'b1, 3'd1, 24'h654321, 1'b0, 4'h0, 1'b0);
                default: idle(b2, 1'b0);
            endcase
        end

        // Frame 5: boundary commit (no overrun), then same-edge write+commit (overrun).
        for (int b = 0; b < 256; b++) begin
            case (b)
                0:       step(b3, 1'b0, 1'b0, 3'd0, 24'h0,      1'b1, 4'hC, 1'b0);
                100:     step(b3, 1'b0, 1'b1, 3'd2, 24'h0000FF, 1'b1, 4'hC, 1'b1);
                default: idle(b3, 1'b0);
            endcase
        end

        // Frame 6: b4 with ch2 still zero; reset lands after bit 130 (a separator '1').
        for (int b = 0; b <= 130; b++) idle(b4, 1'b0);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("async_reset_mid_frame", {bus.out, bus.frame_start, bus.underrun, bus.overrun}, 4'b0000);
        repeat (3) @(negedge clk);
        chk("reset_held", {bus.out, bus.frame_start, bus.underrun, bus.overrun}, 4'b0000);
        q.delete();
        bcnt   = 0;
        fnum   = 100;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // After reset: zero payload restarting at bit 0, then the next frame start.
        repeat (258) idle(z, 1'b1);

        mon_en = 1'b0;
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
